// File: rtl/t06_game_pkg.sv
// Shared encodings and default period constants for the snake game tick generator.
package t06_game_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_STOP_A = 2'b01,
        ST_STOP_B = 2'b10,
        ST_PAUSE  = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        SPD_NORM     = 2'b00,
        SPD_FAST     = 2'b01,
        SPD_SLOW     = 2'b10,
        SPD_NORM_ALT = 2'b11
    } game_speed_e;

    localparam int unsigned DEF_CNT_W       = 22;
    localparam int unsigned DEF_PERIOD_NORM = 2500000;
    localparam int unsigned DEF_PERIOD_FAST = 2000000;
    localparam int unsigned DEF_PERIOD_SLOW = 3000000;
    localparam int unsigned DEF_STEP        = 100000;
    localparam int unsigned DEF_MIN_PERIOD  = 1000000;
    localparam int unsigned DEF_LVL_W       = 4;
    localparam int unsigned DEF_TCNT_W      = 16;

endpackage

// File: rtl/t06_period_calc.sv
// Combinational tick period: per-speed base shortened by level*STEP, clamped at MIN_PERIOD.
module t06_period_calc
    import t06_game_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned PERIOD_NORM = DEF_PERIOD_NORM,
    parameter int unsigned PERIOD_FAST = DEF_PERIOD_FAST,
    parameter int unsigned PERIOD_SLOW = DEF_PERIOD_SLOW,
    parameter int unsigned STEP        = DEF_STEP,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned LVL_W       = DEF_LVL_W
) (
    input  logic [1:0]       speed,
    input  logic [LVL_W-1:0] lvl,
    output logic [CNT_W-1:0] period
);

    localparam int unsigned PW = CNT_W + LVL_W;

    game_speed_e    speed_e;
    logic [PW-1:0]  base_w;
    logic [PW-1:0]  prod_w;
    logic [PW-1:0]  headroom_w;

    assign speed_e = game_speed_e'(speed);

    always_comb begin
        base_w = PW'(PERIOD_NORM);
        case (speed_e)
            SPD_FAST: base_w = PW'(PERIOD_FAST);
            SPD_SLOW: base_w = PW'(PERIOD_SLOW);
            default:  base_w = PW'(PERIOD_NORM);
        endcase
    end

    // Compare the reduction against the headroom so the subtraction can never wrap.
    assign prod_w     = PW'(lvl) * PW'(STEP);
    assign headroom_w = base_w - PW'(MIN_PERIOD);

    always_comb begin
        if (prod_w > headroom_w) begin
            period = CNT_W'(MIN_PERIOD);
        end else begin
            period = CNT_W'(base_w - prod_w);
        end
    end

endmodule

// File: rtl/t06_tick_gen.sv
// Game tick generator: periodic single-cycle tick while running, with pause hold,
// saturating level acceleration, tick counting and period read-back.
module t06_tick_gen
    import t06_game_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned PERIOD_NORM = DEF_PERIOD_NORM,
    parameter int unsigned PERIOD_FAST = DEF_PERIOD_FAST,
    parameter int unsigned PERIOD_SLOW = DEF_PERIOD_SLOW,
    parameter int unsigned STEP        = DEF_STEP,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned LVL_W       = DEF_LVL_W,
    parameter int unsigned TCNT_W      = DEF_TCNT_W
) (
    input  logic              system_clk,
    input  logic              nreset,
    input  logic [1:0]        game_state,
    input  logic [1:0]        game_speed,
    input  logic              level_up,
    output logic              tick,
    output logic              run_en,
    output logic [LVL_W-1:0]  level,
    output logic [CNT_W-1:0]  cur_period,
    output logic [TCNT_W-1:0] tick_count
);

    localparam logic [LVL_W-1:0] LVL_MAX = '1;

    game_state_e       state_e;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              tick_q, tick_d;
    logic              run_en_q, run_en_d;
    logic [LVL_W-1:0]  calc_lvl;
    logic [CNT_W-1:0]  calc_period;

    assign state_e = game_state_e'(game_state);

    // One calculator serves both paths: STOP wants level 0, RUN reloads with the current level.
    assign calc_lvl = (state_e == ST_RUN) ? level_q : '0;

    t06_period_calc #(
        .CNT_W       (CNT_W),
        .PERIOD_NORM (PERIOD_NORM),
        .PERIOD_FAST (PERIOD_FAST),
        .PERIOD_SLOW (PERIOD_SLOW),
        .STEP        (STEP),
        .MIN_PERIOD  (MIN_PERIOD),
        .LVL_W       (LVL_W)
    ) u_period_calc (
        .speed  (game_speed),
        .lvl    (calc_lvl),
        .period (calc_period)
    );

    always_comb begin
        counter_d = counter_q;
        period_d  = period_q;
        level_d   = level_q;
        tcnt_d    = tcnt_q;
        tick_d    = 1'b0;
        run_en_d  = (state_e == ST_RUN);
        case (state_e)
            ST_RUN: begin
                if (counter_q == period_q - CNT_W'(1)) begin
                    counter_d = '0;
                    tick_d    = 1'b1;
                    tcnt_d    = tcnt_q + TCNT_W'(1);
                    period_d  = calc_period;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
                if (level_up && (level_q != LVL_MAX)) begin
                    level_d = level_q + LVL_W'(1);
                end
            end
            ST_PAUSE: begin
                // Everything holds; tick already defaults low.
            end
            default: begin
                counter_d = '0;
                level_d   = '0;
                tcnt_d    = '0;
                period_d  = calc_period;
            end
        endcase
    end

    always_ff @(posedge system_clk or negedge nreset) begin
        if (!nreset) begin
            counter_q <= '0;
            period_q  <= CNT_W'(PERIOD_NORM);
            level_q   <= '0;
            tcnt_q    <= '0;
            tick_q    <= 1'b0;
            run_en_q  <= 1'b0;
        end else begin
            counter_q <= counter_d;
            period_q  <= period_d;
            level_q   <= level_d;
            tcnt_q    <= tcnt_d;
            tick_q    <= tick_d;
            run_en_q  <= run_en_d;
        end
    end

    assign tick       = tick_q;
    assign run_en     = run_en_q;
    assign level      = level_q;
    assign cur_period = period_q;
    assign tick_count = tcnt_q;

endmodule

// File: tb/tb_t06_tick_gen.sv
// Directed, table-driven bench for t06_tick_gen using small period parameters.
module tb_t06_tick_gen;

    localparam int CNT_W  = 8;
    localparam int LVL_W  = 3;
    localparam int TCNT_W = 8;

    logic              system_clk;
    logic              nreset;
    logic [1:0]        game_state;
    logic [1:0]        game_speed;
    logic              level_up;
    logic              tick;
    logic              run_en;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  cur_period;
    logic [TCNT_W-1:0] tick_count;

    int checks = 0;
    int errors = 0;

    t06_tick_gen #(
        .CNT_W       (CNT_W),
        .PERIOD_NORM (10),
        .PERIOD_FAST (8),
        .PERIOD_SLOW (12),
        .STEP        (2),
        .MIN_PERIOD  (4),
        .LVL_W       (LVL_W),
        .TCNT_W      (TCNT_W)
    ) dut (
        .system_clk (system_clk),
        .nreset     (nreset),
        .game_state (game_state),
        .game_speed (game_speed),
        .level_up   (level_up),
        .tick       (tick),
        .run_en     (run_en),
        .level      (level),
        .cur_period (cur_period),
        .tick_count (tick_count)
    );

    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    // Apply inputs for n cycles (level_up only on the first); tick must stay low
    // in the intermediate cycles, and the full record is checked after the last.
    typedef struct {
        int         n;
        logic [1:0] st;
        logic [1:0] sp;
        logic       lu;
        logic       e_tick;
        logic       e_run;
        int         e_lvl;
        int         e_per;
        int         e_tc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int n, logic [1:0] st, logic [1:0] sp, logic lu,
                                logic tk, logic re, int lv, int per, int tc);
        vec_t v;
        v.n = n; v.st = st; v.sp = sp; v.lu = lu;
        v.e_tick = tk; v.e_run = re; v.e_lvl = lv; v.e_per = per; v.e_tc = tc;
        return v;
    endfunction

    task automatic check(string name, int actual, int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_all(string tag, logic tk, logic re, int lv, int per, int tc);
        check({tag, ".tick"},       int'(tick),       int'(tk));
        check({tag, ".run_en"},     int'(run_en),     int'(re));
        check({tag, ".level"},      int'(level),      lv);
        check({tag, ".cur_period"}, int'(cur_period), per);
        check({tag, ".tick_count"}, int'(tick_count), tc);
    endtask

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] P = 2'b11;

    initial begin
        //                n   st  sp     lu  tick run lvl per tc
        vecs.push_back(mk(1,  R,  2'b00, 0,  0,   1,  0,  10, 0)); // run_en after first edge
        vecs.push_back(mk(9,  R,  2'b00, 0,  1,   1,  0,  10, 1)); // first tick at cycle 10
        vecs.push_back(mk(1,  R,  2'b00, 0,  0,   1,  0,  10, 1));
        vecs.push_back(mk(9,  R,  2'b00, 0,  1,   1,  0,  10, 2));
        vecs.push_back(mk(10, R,  2'b00, 0,  1,   1,  0,  10, 3));
        vecs.push_back(mk(3,  R,  2'b00, 1,  0,   1,  1,  10, 3)); // level_up mid-period
        vecs.push_back(mk(1,  R,  2'b00, 1,  0,   1,  2,  10, 3));
        vecs.push_back(mk(6,  R,  2'b00, 0,  1,   1,  2,  6,  4)); // current period still 10
        vecs.push_back(mk(6,  R,  2'b00, 0,  1,   1,  2,  6,  5)); // next period 6
        vecs.push_back(mk(1,  R,  2'b00, 1,  0,   1,  3,  6,  5));
        vecs.push_back(mk(1,  R,  2'b00, 1,  0,   1,  4,  6,  5));
        vecs.push_back(mk(1,  R,  2'b00, 1,  0,   1,  5,  6,  5));
        vecs.push_back(mk(1,  R,  2'b00, 1,  0,   1,  6,  6,  5));
        vecs.push_back(mk(1,  R,  2'b00, 1,  0,   1,  7,  6,  5));
        vecs.push_back(mk(1,  R,  2'b00, 0,  1,   1,  7,  4,  6)); // clamped to MIN_PERIOD
        vecs.push_back(mk(1,  R,  2'b00, 1,  0,   1,  7,  4,  6)); // level saturates
        vecs.push_back(mk(3,  R,  2'b00, 0,  1,   1,  7,  4,  7));
        vecs.push_back(mk(1,  S1, 2'b00, 1,  0,   0,  0,  10, 0)); // STOP clears, ignores level_up
        vecs.push_back(mk(10, R,  2'b00, 0,  1,   1,  0,  10, 1));
        vecs.push_back(mk(5,  R,  2'b00, 0,  0,   1,  0,  10, 1)); // counter = 5
        vecs.push_back(mk(20, P,  2'b00, 1,  0,   0,  0,  10, 1)); // pause holds, level_up ignored
        vecs.push_back(mk(5,  R,  2'b00, 0,  1,   1,  0,  10, 2)); // resume: 5 more cycles
        vecs.push_back(mk(3,  R,  2'b00, 0,  0,   1,  0,  10, 2)); // counter = 3
        vecs.push_back(mk(7,  R,  2'b01, 0,  1,   1,  0,  8,  3)); // speed change waits for reload
        vecs.push_back(mk(7,  R,  2'b01, 0,  0,   1,  0,  8,  3));
        vecs.push_back(mk(1,  R,  2'b01, 1,  1,   1,  1,  8,  4)); // level_up on reload: old level
        vecs.push_back(mk(8,  R,  2'b01, 0,  1,   1,  1,  6,  5));
        vecs.push_back(mk(1,  S2, 2'b10, 0,  0,   0,  0,  12, 0)); // speed in STOP: next cycle
        vecs.push_back(mk(1,  S1, 2'b00, 0,  0,   0,  0,  10, 0));
        vecs.push_back(mk(7,  R,  2'b00, 0,  0,   1,  0,  10, 0)); // counter = 7

        nreset     = 1'b0;
        game_state = R;
        game_speed = 2'b00;
        level_up   = 1'b0;
        repeat (2) @(posedge system_clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 0, 10, 0);
        nreset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                game_state = vecs[i].st;
                game_speed = vecs[i].sp;
                level_up   = (c == 0) ? vecs[i].lu : 1'b0;
                @(posedge system_clk);
                #1;
                if (c != vecs[i].n - 1) begin
                    check($sformatf("vec%0d.c%0d.tick_low", i, c), int'(tick), 0);
                end
            end
            level_up = 1'b0;
            check_all($sformatf("vec%0d", i), vecs[i].e_tick, vecs[i].e_run,
                      vecs[i].e_lvl, vecs[i].e_per, vecs[i].e_tc);
            $display("vec %0d: st=%b sp=%b lu=%b n=%0d -> tick=%b run_en=%b level=%0d period=%0d tcnt=%0d",
                     i, vecs[i].st, vecs[i].sp, vecs[i].lu, vecs[i].n,
                     tick, run_en, level, cur_period, tick_count);
        end

        // Asynchronous reset mid-period (counter = 7): outputs clear without a clock edge.
        nreset = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 1'b0, 0, 10, 0);
        $display("async reset: tick=%b run_en=%b level=%0d period=%0d tcnt=%0d",
                 tick, run_en, level, cur_period, tick_count);
        @(posedge system_clk);
        #1;
        nreset = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge system_clk);
            #1;
            check($sformatf("post_reset.c%0d.tick", c), int'(tick), (c == 10) ? 1 : 0);
        end
        check("post_reset.tick_count", int'(tick_count), 1);
        $display("post reset: first tick after 10 cycles, tcnt=%0d", tick_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
